// File: rtl/router_pkg.sv
// Constants and types shared by the router fan-out and merge stages so
// every port agrees on word width and port index encoding.
package router_pkg;

  localparam int NUM_PORTS = 5;
  localparam int DATA_W    = 32;
  localparam int PORT_W    = 3;

  typedef logic [PORT_W-1:0] port_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over NUM_PORTS requesters; the pointer moves to the
// granted port only on cycles where the consumer takes the grant.
module rr_arbiter
  import router_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic [PORT_W-1:0]    grant,
  output logic                 grant_valid
);

  port_idx_t r_last_grant;

  // Scan starts one past the last winner, so it gets the lowest priority.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!grant_valid && req[(int'(r_last_grant) + k) % NUM_PORTS]) begin
        grant_valid = 1'b1;
        grant       = port_idx_t'((int'(r_last_grant) + k) % NUM_PORTS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= port_idx_t'(NUM_PORTS - 1);
    end else if (advance && grant_valid) begin
      r_last_grant <= grant;
    end
  end

endmodule

// File: rtl/port_merge_arb.sv
// Five-to-one merge stage: round-robin picks one input per cycle and
// registers it, with its source index, into a single valid/ready output slot.
module port_merge_arb
  import router_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  din,
  input  logic [NUM_PORTS-1:0]              din_valid,
  output logic [NUM_PORTS-1:0]              din_ready,
  output logic [DATA_W-1:0]                 dout,
  output logic                              dout_valid,
  input  logic                              dout_ready,
  output logic [PORT_W-1:0]                 src_port
);

  port_idx_t w_grant;
  logic      w_grant_valid;
  logic      w_load_en;
  logic      w_advance;

  word_t     r_dout_p1;
  port_idx_t r_src_p1;
  logic      r_vld_p1;

  rr_arbiter u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (din_valid),
    .advance     (w_advance),
    .grant       (w_grant),
    .grant_valid (w_grant_valid)
  );

  // Slot is free when empty or being drained this cycle; reset blocks accepts.
  assign w_load_en = !r_vld_p1 || dout_ready;
  assign w_advance = rst_n && w_load_en && w_grant_valid;

  always_comb begin
    din_ready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      din_ready[i] = w_advance && (w_grant == port_idx_t'(i));
    end
  end

  // Stage p1: output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dout_p1 <= '0;
      r_src_p1  <= '0;
      r_vld_p1  <= 1'b0;
    end else if (w_load_en) begin
      if (w_grant_valid) begin
        r_dout_p1 <= din[w_grant];
        r_src_p1  <= w_grant;
        r_vld_p1  <= 1'b1;
      end else begin
        r_vld_p1  <= 1'b0;
      end
    end
  end

  assign dout       = r_dout_p1;
  assign src_port   = r_src_p1;
  assign dout_valid = r_vld_p1;

endmodule

// File: tb/tb_port_merge_arb.sv
// Bench for port_merge_arb: directed scenarios plus a randomized run checked
// against a transaction-level model of the round-robin merge.
module tb_port_merge_arb;

  logic            clk;
  logic            rst_n;
  logic [4:0][31:0] din;
  logic [4:0]      din_valid;
  logic [4:0]      din_ready;
  logic [31:0]     dout;
  logic            dout_valid;
  logic            dout_ready;
  logic [2:0]      src_port;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_last;
  logic        m_vld;
  logic [31:0] m_dout;
  int          m_src;

  port_merge_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .src_port   (src_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(int last, logic [4:0] v);
    for (int k = 1; k <= 5; k++) begin
      if (v[(last + k) % 5]) return (last + k) % 5;
    end
    return -1;
  endfunction

  function automatic logic [4:0] exp_ready();
    int g;
    logic [4:0] r;
    r = 5'b0;
    g = pick(m_last, din_valid);
    if (rst_n && (!m_vld || dout_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Advance one clock edge and move the model by one transaction step.
  task automatic tick();
    int          g;
    int          n_last = m_last;
    logic        n_vld  = m_vld;
    logic [31:0] n_dout = m_dout;
    int          n_src  = m_src;
    if (!rst_n) begin
      n_last = 4; n_vld = 1'b0; n_dout = 32'd0; n_src = 0;
    end else if (!m_vld || dout_ready) begin
      g = pick(m_last, din_valid);
      if (g >= 0) begin
        n_dout = din[g]; n_src = g; n_vld = 1'b1; n_last = g;
      end else begin
        n_vld = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_last = n_last; m_vld = n_vld; m_dout = n_dout; m_src = n_src;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din_valid = 5'b0;
    dout_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din_valid = 5'b11111;
    dout_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (din_ready !== 5'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 00000", din_ready);
    end
    tick();
    tick();
    checks++;
    if (dout !== 32'd0 || dout_valid !== 1'b0 || src_port !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: dout=%0d vld=%b src=%0d want 0/0/0", dout, dout_valid, src_port);
    end
    din_valid = 5'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_port();
    din[2] = 32'd3546;
    din_valid = 5'b00100;
    dout_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (din_ready !== 5'b00100) begin
      errors++; $display("FAIL single_ready: got %b want 00100", din_ready);
    end
    tick();
    din_valid = 5'b0;
    checks++;
    if (dout !== 32'd3546 || src_port !== 3'd2 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_out: dout=%0d src=%0d vld=%b want 3546/2/1", dout, src_port, dout_valid);
    end
  endtask

  task automatic test_all_ports();
    do_reset();
    for (int i = 0; i < 5; i++) din[i] = 32'(100 + i);
    din_valid = 5'b11111;
    dout_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checks++;
      if (din_ready !== (5'b00001 << (n % 5))) begin
        errors++; $display("FAIL all_ready[%0d]: got %b want %b", n, din_ready, 5'b00001 << (n % 5));
      end
      tick();
      checks++;
      if (dout !== 32'(100 + n % 5) || src_port !== 3'(n % 5) || dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL all_seq[%0d]: dout=%0d src=%0d vld=%b want %0d/%0d/1",
                 n, dout, src_port, dout_valid, 100 + n % 5, n % 5);
      end
    end
    din_valid = 5'b0;
  endtask

  task automatic test_two_ports();
    int exp_src[3] = '{0, 4, 0};
    do_reset();
    din[0] = 32'hA0A0_0000;
    din[4] = 32'hB4B4_0004;
    din_valid = 5'b10001;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (src_port !== 3'(exp_src[n]) || dout !== din[exp_src[n]] || dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL two_ports[%0d]: src=%0d dout=%h want %0d/%h", n, src_port, dout,
                 exp_src[n], din[exp_src[n]]);
      end
    end
    din_valid = 5'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    do_reset();
    din[0] = 32'h0000_0C0C;
    din[1] = 32'h1111_0001;
    din[3] = 32'h3333_0003;
    din_valid = 5'b00001;
    tick();
    held = 32'h0000_0C0C;
    din_valid = 5'b01010;
    dout_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (din_ready !== 5'b0 || dout !== held || src_port !== 3'd0 || dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold[%0d]: rdy=%b dout=%h src=%0d vld=%b want 00000/%h/0/1",
                 n, din_ready, dout, src_port, dout_valid, held);
      end
      tick();
    end
    dout_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (din_ready !== 5'b00010) begin
      errors++; $display("FAIL release_ready: got %b want 00010", din_ready);
    end
    tick();
    checks++;
    if (dout !== 32'h1111_0001 || src_port !== 3'd1 || dout_valid !== 1'b1) begin
      errors++; $display("FAIL release_out: dout=%h src=%0d want 11110001/1", dout, src_port);
    end
  endtask

  task automatic test_idle();
    din_valid = 5'b0;
    dout_ready = 1'b1;
    tick();
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++; $display("FAIL idle_vld: got %b want 0", dout_valid);
    end
    // Pointer should still sit at port 1, so port 2 wins among all five.
    din_valid = 5'b11111;
    @(negedge clk);
    checks++;
    if (din_ready !== 5'b00100) begin
      errors++; $display("FAIL idle_ptr: got %b want 00100", din_ready);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    din_valid = 5'b11111;
    dout_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre_vld: got %b want 1", dout_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (din_ready !== 5'b0) begin
      errors++; $display("FAIL mid_ready: got %b want 00000", din_ready);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b0 || dout !== 32'd0) begin
      errors++; $display("FAIL mid_state: vld=%b dout=%0d want 0/0", dout_valid, dout);
    end
    rst_n = 1'b1;
    dout_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (din_ready !== 5'b00001) begin
      errors++; $display("FAIL mid_first: got %b want 00001", din_ready);
    end
    tick();
    din_valid = 5'b0;
  endtask

  task automatic test_random();
    logic [4:0] er;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 5; i++) begin
        if (!din_valid[i] && ($urandom_range(0, 2) != 0)) begin
          din_valid[i] = 1'b1;
          din[i] = $urandom;
        end
      end
      dout_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 63) != 0);
      @(negedge clk);
      er = exp_ready();
      checks++;
      if (din_ready !== er) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b want %b", n, din_ready, er);
      end
      tick();
      checks++;
      if (dout_valid !== m_vld || (m_vld && (dout !== m_dout || src_port !== 3'(m_src)))) begin
        errors++;
        $display("FAIL rand_out[%0d]: vld=%b dout=%h src=%0d want %b/%h/%0d",
                 n, dout_valid, dout, src_port, m_vld, m_dout, m_src);
      end
      for (int i = 0; i < 5; i++) if (er[i] || !rst_n) din_valid[i] = 1'b0;
    end
    rst_n = 1'b1;
    din_valid = 5'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    din = '0;
    din_valid = 5'b0;
    dout_ready = 1'b1;
    m_last = 4; m_vld = 1'b0; m_dout = 32'd0; m_src = 0;
    test_reset();
    test_single_port();
    test_all_ports();
    test_two_ports();
    test_backpressure();
    test_idle();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
